digit_serial_alu: RTL and testbench
===================================

Name: digit_serial_alu

Overview:
- Parametrised, sequential successor to the single-bit datapath slice.
- Processes a DATA_W-bit RV32I ALU/compare operation over DATA_W/DIGIT_W cycles, one DIGIT_W-bit digit per cycle, LSB digit first.
- A registered carry/compare chain replaces the spatial ripple between slices.
- Sits between regfile read and writeback/branch logic; uses a valid/ready handshake on both request and response sides.

Parameters:
- DATA_W, 32, operand and result width.
- DIGIT_W, 4, bits processed per cycle. Must divide DATA_W; elaboration-time assertion otherwise.
- NDIG, DATA_W/DIGIT_W, derived digit count. Not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  op_t operation code
- req_a  in  DATA_W  operand A (rs1 or pc)
- req_b  in  DATA_W  operand B (rs2 or imm)
- req_shamt  in  5  shift amount; used only with DSA_SHIFT_EN
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  DATA_W  result word
- resp_cmp  out  1  compare flag (LT/LTU/EQ); 0 for non-compare ops

Behaviour:
- Reset (synchronous, active-high): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_cmp=0, carry=0, eq_acc=1, digit counter=0. Reset wins over every other event, including mid-RUN; an in-flight operation is discarded with no response.
- States:
  - IDLE: req_ready=1. On req_valid, latch op, a, b and shamt; go to RUN; counter=0.
  - RUN: req_ready=0. Each cycle, process digit[counter] and write it into the result register at position counter. Counter increments; at counter==NDIG-1 go to DONE.
  - DONE: resp_valid=1. resp_data and resp_cmp are stable while resp_valid&&!resp_ready. On resp_ready go to IDLE. No accept in the same cycle as the DONE->IDLE transition.
- Latency: acceptance edge E0 leads to resp_valid high after edge E_NDIG. Throughput is one op per NDIG+2 cycles.
- Per-op rules:
  - ADD: carry initialised to 0 at accept.
  - SUB, SLT, SLTU: operand B is inverted per digit; carry initialised to 1.
  - The carry register holds the digit carry-out between cycles.
  - AND/OR/XOR: bitwise per digit; carry is unused.
  - EQ: eq_acc &= (digit_a == digit_b) each cycle. resp_cmp = eq_acc after the last digit.
  - SLTU: resp_cmp = ~final carry-out.
  - SLT: resp_cmp = (a_msb != b_msb) ? a_msb : diff_msb, with MSBs taken from the last digit.
  - Compare ops return resp_data = {DATA_W-1 zeros, resp_cmp}.
  - Arithmetic wraps modulo 2^DATA_W; overflow is not flagged.
- Illegal ops (8-15 without the macro, 11-15 with it): take NDIG cycles, resp_data=0, resp_cmp=0.
- DIGIT_W==DATA_W (NDIG=1): RUN lasts exactly one cycle.

Optional Feature:
- Macro: DSA_SHIFT_EN.
- Defined:
  - Ops SLL=8, SRL=9, SRA=10 are enabled.
  - RUN shifts the latched A by 1 bit per cycle for shamt cycles: SRA fills with the sign bit, the others fill with zero.
  - shamt==0 takes one RUN cycle with the result equal to A.
  - Latency to resp_valid is max(shamt,1) edges after accept.
- Undefined: no shift datapath is present, req_shamt is ignored, and ops 8-10 behave as illegal ops.

Decomposition:
- Package dsa_pkg holds:
  - op_t: 4-bit enum ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, EQ=7, SLL=8, SRL=9, SRA=10.
  - state_t: IDLE, RUN, DONE.
  - helper functions is_cmp(op) and needs_inv(op).
- Sub-module dsa_digit: combinational, DIGIT_W-wide. Inputs a, b, inv_b, cin, op. Outputs res, cout, and the digit eq flag. The top holds the FSM, counter, operand/result registers and shift logic.

Test Plan (DATA_W=32, DIGIT_W=4 unless stated):
- ADD 0x7FFFFFFF + 0x00000001 -> resp_valid exactly 8 cycles after accept, resp_data=0x80000000, resp_cmp=0.
- SUB 5 - 7 -> 0xFFFFFFFE. Then SLT 0xFFFFFFFF vs 1 -> resp_cmp=1, resp_data=1. Then SLTU same operands -> resp_cmp=0, resp_data=0.
- EQ 0x12345678 vs 0x12345678 -> resp_cmp=1. EQ with only bit 31 differing -> resp_cmp=0.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_data stable and req_ready=0 throughout. A pulse of resp_ready returns the block to IDLE, and req_ready=1 on the next cycle.
- Reset: assert rst at RUN cycle 3 of an ADD -> next cycle IDLE with req_ready=1, resp_valid=0, and no response ever appears. A fresh XOR 0xF0F0F0F0 ^ 0xFFFFFFFF then returns 0x0F0F0F0F.
- DIGIT_W=32: ADD 1+1 -> resp_valid 1 cycle after accept, result 2. With DSA_SHIFT_EN: SRA 0x80000000 shamt 4 -> 0xF8000000 after 4 cycles; SLL shamt 0 returns A after 1 cycle.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial RV32I ALU.
// op_t    : 4-bit operation code (ADD..EQ always, SLL/SRL/SRA with DSA_SHIFT_EN)
// state_t : sequencer states
// is_cmp / needs_inv : op classification used by the top and the digit slice
package dsa_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    EQ   = 4'd7,
    SLL  = 4'd8,
    SRL  = 4'd9,
    SRA  = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops whose result is the single compare flag
  function automatic logic is_cmp(input op_t op);
    return (op == SLT) || (op == SLTU) || (op == EQ);
  endfunction

  // Ops computed as a + ~b + 1
  function automatic logic needs_inv(input op_t op);
    return (op == SUB) || (op == SLT) || (op == SLTU);
  endfunction

endpackage

// File: rtl/dsa_digit.sv
// One DIGIT_W-bit slice of the ALU datapath (purely combinational).
// Ports:
//   a, b   : operand digits
//   inv_b  : invert b before the adder (subtract / compare)
//   cin    : carry into this digit
//   op     : operation code
//   res    : result digit (0 for EQ and illegal ops)
//   cout   : carry out of this digit
//   eq     : a == b for this digit
module dsa_digit
  import dsa_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               inv_b,
  input  logic               cin,
  input  op_t                op,
  output logic [DIGIT_W-1:0] res,
  output logic               cout,
  output logic               eq
);

  localparam int unsigned SUM_W = DIGIT_W + 1;

  logic [DIGIT_W-1:0] w_b_eff;
  logic [SUM_W-1:0]   w_sum;

  assign w_b_eff = inv_b ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + SUM_W'(cin);
  assign cout    = w_sum[DIGIT_W];
  assign eq      = (a == b);

  // Result digit select
  always_comb begin
    res = '0;
    case (op)
      ADD, SUB, SLT, SLTU: res = w_sum[DIGIT_W-1:0];
      AND:                 res = a & b;
      OR:                  res = a | b;
      XOR:                 res = a ^ b;
      default:             res = '0;
    endcase
  end

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial RV32I ALU/compare unit: one DIGIT_W-bit digit per cycle,
// LSB digit first, carry and equality chained through registers.
// Optional feature macro: DSA_SHIFT_EN (enables SLL/SRL/SRA, 1 bit per cycle).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid / req_ready  : request handshake
//   req_op, req_a, req_b   : operation and operands
//   req_shamt              : shift amount (only with DSA_SHIFT_EN)
//   resp_valid / resp_ready: response handshake
//   resp_data, resp_cmp    : result word and compare flag
module digit_serial_alu
  import dsa_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  op_t               req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [4:0]        req_shamt,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_cmp
);

  localparam int unsigned NDIG  = DATA_W / DIGIT_W;
  localparam int unsigned CNT_W = ($clog2(NDIG + 1) > 5) ? $clog2(NDIG + 1) : 5;

  if ((DATA_W % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("digit_serial_alu: DIGIT_W must divide DATA_W");
  end

  state_t             r_state;
  op_t                r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_res;
  logic               r_carry;
  logic               r_eq;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_resp_cmp;

  logic [DIGIT_W-1:0] w_dig_a;
  logic [DIGIT_W-1:0] w_dig_b;
  logic [DIGIT_W-1:0] w_dig_res;
  logic               w_cout;
  logic               w_eq;
  logic [DATA_W-1:0]  w_res_full;
  logic               w_cmp_fin;
  logic               w_is_shift;
  logic               w_legal;
  logic               w_shift_last;
  logic [DATA_W-1:0]  w_shift_res;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_res;
  assign resp_cmp   = r_resp_cmp;

  // Operands are shifted right each RUN cycle, so the current digit is always the LSBs
  assign w_dig_a = r_a[DIGIT_W-1:0];
  assign w_dig_b = r_b[DIGIT_W-1:0];

  dsa_digit #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a    (w_dig_a),
    .b    (w_dig_b),
    .inv_b(needs_inv(r_op)),
    .cin  (r_carry),
    .op   (r_op),
    .res  (w_dig_res),
    .cout (w_cout),
    .eq   (w_eq)
  );

  // Result fills from the top; after NDIG digits every digit sits at its own position
  assign w_res_full = (r_res >> DIGIT_W) | (DATA_W'(w_dig_res) << (DATA_W - DIGIT_W));

  // Final compare flag, valid on the last digit cycle
  always_comb begin
    w_cmp_fin = 1'b0;
    case (r_op)
      SLTU:    w_cmp_fin = ~w_cout;
      SLT:     w_cmp_fin = (w_dig_a[DIGIT_W-1] != w_dig_b[DIGIT_W-1]) ?
                           w_dig_a[DIGIT_W-1] : w_dig_res[DIGIT_W-1];
      EQ:      w_cmp_fin = r_eq & w_eq;
      default: w_cmp_fin = 1'b0;
    endcase
  end

`ifdef DSA_SHIFT_EN
  logic [4:0]        r_shamt;
  logic [DATA_W-1:0] w_shift1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shamt <= '0;
    end else if ((r_state == IDLE) && req_valid) begin
      r_shamt <= req_shamt;
    end
  end

  // One-bit shift step
  always_comb begin
    w_shift1 = r_a;
    case (r_op)
      SLL:     w_shift1 = r_a << 1;
      SRL:     w_shift1 = r_a >> 1;
      SRA:     w_shift1 = {r_a[DATA_W-1], r_a[DATA_W-1:1]};
      default: w_shift1 = r_a;
    endcase
  end

  assign w_is_shift   = (r_op == SLL) || (r_op == SRL) || (r_op == SRA);
  // shamt==0 still spends one RUN cycle and passes A through
  assign w_shift_res  = (r_shamt == 5'd0) ? r_a : w_shift1;
  assign w_shift_last = (r_shamt == 5'd0) || (r_cnt == (CNT_W'(r_shamt) - CNT_W'(1)));
`else
  logic w_unused_shamt;
  assign w_unused_shamt = ^req_shamt;
  assign w_is_shift     = 1'b0;
  assign w_shift_res    = '0;
  assign w_shift_last   = 1'b1;
`endif

  assign w_legal = (4'(r_op) <= 4'(EQ)) || w_is_shift;

  // Sequencer, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op         <= ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_carry      <= 1'b0;
      r_eq         <= 1'b1;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_cmp   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_a         <= req_a;
            r_b         <= req_b;
            r_res       <= '0;
            r_carry     <= needs_inv(req_op);
            r_eq        <= 1'b1;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_shift) begin
            r_a <= w_shift_res;
            if (w_shift_last) begin
              r_res        <= w_shift_res;
              r_resp_cmp   <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= DONE;
            end
          end else begin
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_carry <= w_cout;
            r_eq    <= r_eq & w_eq;
            r_res   <= w_res_full;
            if (r_cnt == CNT_W'(NDIG - 1)) begin
              if (!w_legal) begin
                r_res      <= '0;
                r_resp_cmp <= 1'b0;
              end else if (is_cmp(r_op)) begin
                r_res      <= DATA_W'(w_cmp_fin);
                r_resp_cmp <= w_cmp_fin;
              end else begin
                r_resp_cmp <= 1'b0;
              end
              r_resp_valid <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Self-checking bench for digit_serial_alu: a 4-bit-digit instance driven from a
// vector table plus hand sequences (backpressure, mid-run reset), and a
// single-digit (DIGIT_W=32) instance for the one-cycle RUN case.
module tb_digit_serial_alu;
  import dsa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid4;
  logic        req_valid32;
  op_t         req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_shamt;
  logic        resp_ready;

  logic        req_ready4,  resp_valid4,  resp_cmp4;
  logic [31:0] resp_data4;
  logic        req_ready32, resp_valid32, resp_cmp32;
  logic [31:0] resp_data32;

  always #5 clk = ~clk;

  digit_serial_alu #(.DATA_W(32), .DIGIT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_data(resp_data4), .resp_cmp(resp_cmp4)
  );

  digit_serial_alu #(.DATA_W(32), .DIGIT_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(req_ready32),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .resp_valid(resp_valid32), .resp_ready(resp_ready),
    .resp_data(resp_data32), .resp_cmp(resp_cmp32)
  );

  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_data;
    logic        exp_cmp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input op_t op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [31:0] d, input logic c,
                              input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.exp_data = d; v.exp_cmp = c; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one op to the chosen instance, wait for the response, then accept it
  task automatic run_op(input bit wide, input op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        output logic [31:0] data, output logic cmp, output int lat);
    int guard = 0;
    while (!(wide ? req_ready32 : req_ready4) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("req_ready_before_issue", 32'(wide ? req_ready32 : req_ready4), 32'd1);
    req_op = op; req_a = a; req_b = b; req_shamt = sh;
    if (wide) req_valid32 = 1'b1; else req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0; req_valid32 = 1'b0;
    lat = 0;
    while (!(wide ? resp_valid32 : resp_valid4) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    data = wide ? resp_data32 : resp_data4;
    cmp  = wide ? resp_cmp32  : resp_cmp4;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        c;
    int          lat;
    int          guard;
    logic        seen;

    vecs.push_back(mk(ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 8));
    vecs.push_back(mk(SUB,  32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 1'b0, 8));
    vecs.push_back(mk(SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b1, 8));
    vecs.push_back(mk(SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 8));
    vecs.push_back(mk(EQ,   32'h12345678, 32'h12345678, 5'd0, 32'h00000001, 1'b1, 8));
    vecs.push_back(mk(EQ,   32'h92345678, 32'h12345678, 5'd0, 32'h00000000, 1'b0, 8));
    vecs.push_back(mk(AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 5'd0, 32'h30303030, 1'b0, 8));
    vecs.push_back(mk(OR,   32'h0F000000, 32'h000000F0, 5'd0, 32'h0F0000F0, 1'b0, 8));
    vecs.push_back(mk(XOR,  32'hF0F0F0F0, 32'hFFFFFFFF, 5'd0, 32'h0F0F0F0F, 1'b0, 8));
    vecs.push_back(mk(SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b0, 8));
    vecs.push_back(mk(SLTU, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b1, 8));
    vecs.push_back(mk(SLT,  32'h80000000, 32'h80000001, 5'd0, 32'h00000001, 1'b1, 8));
    vecs.push_back(mk(ADD,  32'hFFFFFFFF, 32'h00000002, 5'd0, 32'h00000001, 1'b0, 8));
    vecs.push_back(mk(op_t'(4'd12), 32'h12345678, 32'h11111111, 5'd3, 32'h00000000, 1'b0, 8));
`ifdef DSA_SHIFT_EN
    vecs.push_back(mk(SRL,  32'hF0000000, 32'h0, 5'd4,  32'h0F000000, 1'b0, 4));
    vecs.push_back(mk(SRA,  32'h80000000, 32'h0, 5'd4,  32'hF8000000, 1'b0, 4));
    vecs.push_back(mk(SLL,  32'h12345678, 32'h0, 5'd0,  32'h12345678, 1'b0, 1));
    vecs.push_back(mk(SLL,  32'h00000001, 32'h0, 5'd31, 32'h80000000, 1'b0, 31));
`else
    vecs.push_back(mk(SRL,  32'hF0000000, 32'h0, 5'd4,  32'h00000000, 1'b0, 8));
    vecs.push_back(mk(SLL,  32'h12345678, 32'h0, 5'd1,  32'h00000000, 1'b0, 8));
`endif

    rst = 1'b1; req_valid4 = 1'b0; req_valid32 = 1'b0; resp_ready = 1'b0;
    req_op = ADD; req_a = '0; req_b = '0; req_shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_req_ready",  32'(req_ready4),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid4), 32'd0);
    chk("rst_resp_data",  resp_data4,       32'd0);
    chk("rst_resp_cmp",   32'(resp_cmp4),   32'd0);
    chk("rst_req_ready32", 32'(req_ready32), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, d, c, lat);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_cmp", i), 32'(c), 32'(vecs[i].exp_cmp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: response held stable while resp_ready stays low
    req_op = ADD; req_a = 32'd3; req_b = 32'd4; req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    chk("bp_req_ready_in_run", 32'(req_ready4), 32'd0);
    guard = 0;
    while (!resp_valid4 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k),     32'(resp_valid4), 32'd1);
      chk($sformatf("bp_data_%0d", k),      resp_data4,       32'd7);
      chk($sformatf("bp_req_ready_%0d", k), 32'(req_ready4),  32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_release_req_ready",  32'(req_ready4),  32'd1);
    chk("bp_release_resp_valid", 32'(resp_valid4), 32'd0);

    // Reset during RUN cycle 3 discards the op
    req_op = ADD; req_a = 32'd1; req_b = 32'd2; req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req_ready",  32'(req_ready4),  32'd1);
    chk("midrst_resp_valid", 32'(resp_valid4), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (resp_valid4) seen = 1'b1;
    end
    chk("midrst_no_response", 32'(seen), 32'd0);
    run_op(1'b0, XOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 5'd0, d, c, lat);
    chk("midrst_xor_data",    d,          32'h0F0F0F0F);
    chk("midrst_xor_latency", 32'(lat),   32'd8);

    // Single-digit instance: RUN lasts one cycle
    run_op(1'b1, ADD, 32'd1, 32'd1, 5'd0, d, c, lat);
    chk("w32_add_data",    d,        32'd2);
    chk("w32_add_latency", 32'(lat), 32'd1);
    run_op(1'b1, SLTU, 32'd1, 32'd2, 5'd0, d, c, lat);
    chk("w32_sltu_cmp",    32'(c),   32'd1);
    chk("w32_sltu_data",   d,        32'd1);
`ifdef DSA_SHIFT_EN
    run_op(1'b1, SRA, 32'h80000000, 32'd0, 5'd4, d, c, lat);
    chk("w32_sra_data",    d,        32'hF8000000);
    chk("w32_sra_latency", 32'(lat), 32'd4);
    run_op(1'b1, SLL, 32'hDEADBEEF, 32'd0, 5'd0, d, c, lat);
    chk("w32_sll0_data",    d,        32'hDEADBEEF);
    chk("w32_sll0_latency", 32'(lat), 32'd1);
`else
    run_op(1'b1, SRA, 32'h80000000, 32'd0, 5'd4, d, c, lat);
    chk("w32_sra_illegal_data",    d,        32'd0);
    chk("w32_sra_illegal_latency", 32'(lat), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
